// File: rtl/interrupt_controller_if.sv
// Interrupt controller bus: device request lines, control-unit handshake and debug view.
// The controller takes the slave modport; the control-unit side takes master.
interface interrupt_controller_if #(
  parameter int InterruptsNum = 2
) ();
  logic [InterruptsNum-1:0] interrupt;
  logic                     GIE;
  logic                     MaskIn;
  logic [InterruptsNum-1:0] MaskData;
  logic                     IntAck;
  logic                     Iret;
  logic                     IntReq;
  logic [3:0]               IntId;
  logic [31:0]              IntVector;
  logic                     InService;
  logic [InterruptsNum-1:0] Pending;

  modport master (
    output interrupt, GIE, MaskIn, MaskData, IntAck, Iret,
    input  IntReq, IntId, IntVector, InService, Pending
  );

  modport slave (
    input  interrupt, GIE, MaskIn, MaskData, IntAck, Iret,
    output IntReq, IntId, IntVector, InService, Pending
  );
endinterface

// File: rtl/interrupt_controller.sv
// Prioritised interrupt controller (lowest index wins) with request/ack/iret handshake.
// Define INT_EDGE_DETECT_EN for edge-latched pending bits; otherwise requests are level-sensitive.
module interrupt_controller #(
  parameter int          InterruptsNum = 2,
  parameter logic [31:0] VectorBase    = 32'h0000_0100
) (
  input  logic                   Clock,
  input  logic                   Reset,
  interrupt_controller_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    SERVICE
  } state_e;

  state_e                   state_q, state_d;
  logic [InterruptsNum-1:0] mask_q;
  logic [InterruptsNum-1:0] pending;
  logic [InterruptsNum-1:0] eligible;
  logic                     any_eligible;
  logic                     ack_take;
  logic [3:0]               sel;
  logic [3:0]               int_id_q, int_id_d;
  logic                     int_req;
  logic                     in_service;

  assign eligible     = pending & mask_q & {InterruptsNum{bus.GIE}};
  assign any_eligible = |eligible;
  // An ack only counts while a winner still exists on that edge.
  assign ack_take     = (state_q == REQ) && bus.IntAck && any_eligible;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    sel = '0;
    for (int i = InterruptsNum - 1; i >= 0; i--) begin
      if (eligible[i]) sel = 4'(i);
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      mask_q <= '0;
    end else if (bus.MaskIn) begin
      mask_q <= bus.MaskData;
    end
  end

`ifdef INT_EDGE_DETECT_EN
  logic [InterruptsNum-1:0] pending_q, pending_d;
  logic [InterruptsNum-1:0] hist_q;
  logic [InterruptsNum-1:0] ack_clr;

  always_comb begin
    ack_clr = '0;
    for (int i = 0; i < InterruptsNum; i++) begin
      ack_clr[i] = ack_take && (sel == 4'(i));
    end
  end

  // A fresh rising edge on the ack edge re-arms the bit: set wins over clear.
  assign pending_d = (pending_q & ~ack_clr) | (bus.interrupt & ~hist_q);

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      pending_q <= '0;
      hist_q    <= '0;
    end else begin
      pending_q <= pending_d;
      hist_q    <= bus.interrupt;
    end
  end

  assign pending = pending_q;
`else
  assign pending = bus.interrupt;
`endif

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q  <= IDLE;
      int_id_q <= '0;
    end else begin
      state_q  <= state_d;
      int_id_q <= int_id_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (any_eligible) state_d = REQ;
      REQ: begin
        if (!any_eligible)    state_d = IDLE;
        else if (bus.IntAck)  state_d = SERVICE;
      end
      SERVICE: if (bus.Iret) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    int_req    = (state_q == REQ);
    in_service = (state_q == SERVICE);
    int_id_d   = ack_take ? sel : int_id_q;
  end

  assign bus.IntReq    = int_req;
  assign bus.InService = in_service;
  assign bus.IntId     = int_id_q;
  assign bus.IntVector = VectorBase + {26'b0, int_id_q, 2'b00};
  assign bus.Pending   = pending;

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed self-checking bench for interrupt_controller; expectations follow the
// build mode selected by INT_EDGE_DETECT_EN.
module tb_interrupt_controller;

  logic Clock;
  logic Reset;
  int   checks;
  int   errors;

  interrupt_controller_if #(.InterruptsNum(2)) ifc ();

  interrupt_controller #(
    .InterruptsNum(2),
    .VectorBase   (32'h0000_0100)
  ) dut (
    .Clock(Clock),
    .Reset(Reset),
    .bus  (ifc)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic cycle(input int n);
    repeat (n) begin
      @(posedge Clock);
      #1;
    end
  endtask

  task automatic write_mask(input logic [1:0] m);
    ifc.MaskIn   = 1'b1;
    ifc.MaskData = m;
    cycle(1);
    ifc.MaskIn   = 1'b0;
  endtask

  task automatic pulse_ack();
    ifc.IntAck = 1'b1;
    cycle(1);
    ifc.IntAck = 1'b0;
  endtask

  task automatic pulse_iret();
    ifc.Iret = 1'b1;
    cycle(1);
    ifc.Iret = 1'b0;
  endtask

  task automatic wait_req(input string name);
    int n;
    n = 0;
    while (ifc.IntReq !== 1'b1 && n < 4) begin
      cycle(1);
      n++;
    end
    checks++;
    if (ifc.IntReq !== 1'b1) begin
      errors++;
      $display("FAIL %s: IntReq=%b after %0d cycles, required 1", name, ifc.IntReq, n);
    end
  endtask

  task automatic test_reset();
    Reset         = 1'b0;
    ifc.interrupt = '0;
    ifc.GIE       = 1'b0;
    ifc.MaskIn    = 1'b0;
    ifc.MaskData  = '0;
    ifc.IntAck    = 1'b0;
    ifc.Iret      = 1'b0;
    #1;
    checks++; if (ifc.IntReq !== 1'b0) begin errors++; $display("FAIL reset_intreq: got %b want 0", ifc.IntReq); end
    checks++; if (ifc.IntId !== 4'd0) begin errors++; $display("FAIL reset_intid: got %0d want 0", ifc.IntId); end
    checks++; if (ifc.IntVector !== 32'h100) begin errors++; $display("FAIL reset_vector: got %h want 00000100", ifc.IntVector); end
    checks++; if (ifc.InService !== 1'b0) begin errors++; $display("FAIL reset_inservice: got %b want 0", ifc.InService); end
    checks++; if (ifc.Pending !== 2'b00) begin errors++; $display("FAIL reset_pending: got %b want 00", ifc.Pending); end
    cycle(2);
    Reset = 1'b1;
    cycle(1);
  endtask

  task automatic test_latency();
    ifc.GIE = 1'b1;
    write_mask(2'b01);
    ifc.interrupt = 2'b01;
    cycle(1);
    checks++; if (ifc.Pending !== 2'b01) begin errors++; $display("FAIL lat_pending: got %b want 01", ifc.Pending); end
`ifdef INT_EDGE_DETECT_EN
    checks++; if (ifc.IntReq !== 1'b0) begin errors++; $display("FAIL lat_req_e0: got %b want 0", ifc.IntReq); end
    cycle(1);
`endif
    checks++; if (ifc.IntReq !== 1'b1) begin errors++; $display("FAIL lat_req: got %b want 1", ifc.IntReq); end
    pulse_ack();
    checks++; if (ifc.IntId !== 4'd0) begin errors++; $display("FAIL lat_id: got %0d want 0", ifc.IntId); end
    checks++; if (ifc.IntVector !== 32'h100) begin errors++; $display("FAIL lat_vector: got %h want 00000100", ifc.IntVector); end
    checks++; if (ifc.InService !== 1'b1) begin errors++; $display("FAIL lat_inservice: got %b want 1", ifc.InService); end
    checks++; if (ifc.IntReq !== 1'b0) begin errors++; $display("FAIL lat_req_after_ack: got %b want 0", ifc.IntReq); end
`ifdef INT_EDGE_DETECT_EN
    checks++; if (ifc.Pending !== 2'b00) begin errors++; $display("FAIL lat_pending_clr: got %b want 00", ifc.Pending); end
`else
    checks++; if (ifc.Pending !== 2'b01) begin errors++; $display("FAIL lat_pending_lvl: got %b want 01", ifc.Pending); end
`endif
    ifc.interrupt = 2'b00;
    pulse_iret();
    checks++; if (ifc.InService !== 1'b0) begin errors++; $display("FAIL lat_iret: got %b want 0", ifc.InService); end
    cycle(1);
    checks++; if (ifc.IntReq !== 1'b0) begin errors++; $display("FAIL lat_idle: got %b want 0", ifc.IntReq); end
  endtask

  task automatic test_priority();
    logic [1:0] exp_p;
    write_mask(2'b11);
    ifc.interrupt = 2'b10;
    cycle(1);
    ifc.interrupt = 2'b11;
    cycle(1);
    checks++; if (ifc.IntReq !== 1'b1) begin errors++; $display("FAIL prio_req: got %b want 1", ifc.IntReq); end
    pulse_ack();
    checks++; if (ifc.IntId !== 4'd0) begin errors++; $display("FAIL prio_id0: got %0d want 0", ifc.IntId); end
    checks++; if (ifc.IntVector !== 32'h100) begin errors++; $display("FAIL prio_vec0: got %h want 00000100", ifc.IntVector); end
    ifc.interrupt = 2'b10;
    pulse_iret();
    checks++; if (ifc.IntReq !== 1'b0) begin errors++; $display("FAIL prio_req_iret: got %b want 0", ifc.IntReq); end
    cycle(1);
    checks++; if (ifc.IntReq !== 1'b1) begin errors++; $display("FAIL prio_rereq: got %b want 1", ifc.IntReq); end
    pulse_ack();
    checks++; if (ifc.IntId !== 4'd1) begin errors++; $display("FAIL prio_id1: got %0d want 1", ifc.IntId); end
    checks++; if (ifc.IntVector !== 32'h104) begin errors++; $display("FAIL prio_vec1: got %h want 00000104", ifc.IntVector); end
`ifdef INT_EDGE_DETECT_EN
    exp_p = 2'b00;
`else
    exp_p = 2'b10;
`endif
    checks++; if (ifc.Pending !== exp_p) begin errors++; $display("FAIL prio_pending: got %b want %b", ifc.Pending, exp_p); end
    ifc.interrupt = 2'b00;
    pulse_iret();
    cycle(1);
  endtask

  task automatic test_no_nesting();
    ifc.interrupt = 2'b01;
    wait_req("nest_req0");
    pulse_ack();
    ifc.interrupt = 2'b10;
    cycle(1);
    checks++; if (ifc.Pending[1] !== 1'b1) begin errors++; $display("FAIL nest_pending1: got %b want 1", ifc.Pending[1]); end
    checks++; if (ifc.IntReq !== 1'b0) begin errors++; $display("FAIL nest_noreq: got %b want 0", ifc.IntReq); end
    cycle(1);
    checks++; if (ifc.IntReq !== 1'b0) begin errors++; $display("FAIL nest_noreq2: got %b want 0", ifc.IntReq); end
    pulse_iret();
    checks++; if (ifc.IntReq !== 1'b0) begin errors++; $display("FAIL nest_req_at_iret: got %b want 0", ifc.IntReq); end
    cycle(1);
    checks++; if (ifc.IntReq !== 1'b1) begin errors++; $display("FAIL nest_req_after: got %b want 1", ifc.IntReq); end
    pulse_ack();
    checks++; if (ifc.IntId !== 4'd1) begin errors++; $display("FAIL nest_id1: got %0d want 1", ifc.IntId); end
    ifc.interrupt = 2'b00;
    pulse_iret();
    cycle(1);
  endtask

  task automatic test_withdrawal();
    write_mask(2'b10);
    ifc.interrupt = 2'b10;
    wait_req("wd_req");
    pulse_iret();
    checks++; if (ifc.IntReq !== 1'b1) begin errors++; $display("FAIL wd_iret_ignored: got %b want 1", ifc.IntReq); end
    write_mask(2'b00);
    cycle(1);
    checks++; if (ifc.IntReq !== 1'b0) begin errors++; $display("FAIL wd_drop: got %b want 0", ifc.IntReq); end
    checks++; if (ifc.Pending[1] !== 1'b1) begin errors++; $display("FAIL wd_pending: got %b want 1", ifc.Pending[1]); end
    write_mask(2'b10);
    checks++; if (ifc.IntReq !== 1'b0) begin errors++; $display("FAIL wd_mask_delay: got %b want 0", ifc.IntReq); end
    cycle(1);
    checks++; if (ifc.IntReq !== 1'b1) begin errors++; $display("FAIL wd_restore: got %b want 1", ifc.IntReq); end
    pulse_ack();
    ifc.interrupt = 2'b00;
    pulse_iret();
    cycle(1);
    pulse_ack();
    checks++; if (ifc.InService !== 1'b0) begin errors++; $display("FAIL ack_ignored_idle: got %b want 0", ifc.InService); end
  endtask

  task automatic test_collision();
    write_mask(2'b01);
    ifc.interrupt = 2'b01;
    wait_req("col_req");
`ifdef INT_EDGE_DETECT_EN
    ifc.interrupt = 2'b00;
    cycle(1);
    ifc.interrupt = 2'b01;
    pulse_ack();
    checks++; if (ifc.Pending[0] !== 1'b1) begin errors++; $display("FAIL col_pending: got %b want 1", ifc.Pending[0]); end
    checks++; if (ifc.InService !== 1'b1) begin errors++; $display("FAIL col_inservice: got %b want 1", ifc.InService); end
    ifc.interrupt = 2'b00;
    pulse_iret();
    wait_req("col_rereq");
    pulse_ack();
    pulse_iret();
`else
    pulse_ack();
    checks++; if (ifc.Pending[0] !== 1'b1) begin errors++; $display("FAIL lvl_ack_noclear: got %b want 1", ifc.Pending[0]); end
    checks++; if (ifc.InService !== 1'b1) begin errors++; $display("FAIL lvl_inservice: got %b want 1", ifc.InService); end
    ifc.interrupt = 2'b00;
    pulse_iret();
`endif
    cycle(2);
  endtask

  task automatic test_reset_mid_req();
    logic [1:0] exp_p;
    write_mask(2'b11);
    ifc.interrupt = 2'b01;
    wait_req("rst_req");
    Reset = 1'b0;
    #1;
`ifdef INT_EDGE_DETECT_EN
    exp_p = 2'b00;
`else
    exp_p = 2'b01;
`endif
    checks++; if (ifc.IntReq !== 1'b0) begin errors++; $display("FAIL rst_async_req: got %b want 0", ifc.IntReq); end
    checks++; if (ifc.InService !== 1'b0) begin errors++; $display("FAIL rst_async_insvc: got %b want 0", ifc.InService); end
    checks++; if (ifc.Pending !== exp_p) begin errors++; $display("FAIL rst_async_pending: got %b want %b", ifc.Pending, exp_p); end
    cycle(1);
    Reset = 1'b1;
    cycle(3);
    checks++; if (ifc.IntReq !== 1'b0) begin errors++; $display("FAIL rst_mask_cleared: got %b want 0", ifc.IntReq); end
    ifc.interrupt = 2'b00;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_latency();
    test_priority();
    test_no_nesting();
    test_withdrawal();
    test_collision();
    test_reset_mid_req();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
